uart_tx_arbiter: RTL

//   Shares one uartTX transmitter among NREQ byte requesters.

---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: frame length, FSM states, clog2.
package uart_tx_arbiter_pkg;

    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STROBE     = 2'd1,
        WAIT_FRAME = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating picker: first set req scanning upward from ptr+1, wrapping at NREQ.
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    logic [IW-1:0] j;

    // Walk from the farthest candidate to the nearest so the nearest set one is kept.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        j      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (req[j]) begin
                winner = j;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uartTX among NREQ byte requesters and paces strobes to the serial frame.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int CLKS_PER_BIT  = 5208,
    parameter int DATAOK_CYCLES = 16,
    parameter int GAP_BITS      = 1,
    localparam int IW           = clog2(NREQ)
) (
    input  logic              clk50m,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        txdata,
    output logic              dataok,
    output logic              busy,
    output logic [IW-1:0]     grant_id
);

    localparam int FRAME_CYC = (UART_FRAME_BITS + GAP_BITS) * CLKS_PER_BIT;
    localparam int CW        = clog2(FRAME_CYC + 1);
    localparam logic [CW-1:0] DOK_LAST = CW'(DATAOK_CYCLES - 1);
    localparam logic [CW-1:0] FRM_LAST = CW'(FRAME_CYC - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick;
    logic          pick_vld;
    logic [7:0]    bytes [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_bytes
        assign bytes[i] = req_data[8*i +: 8];
    end

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // Starting the scan just past NREQ-1 makes the picker a plain priority encoder.
    assign ptr = IW'(NREQ - 1);
`else
    logic [IW-1:0] rr_ptr;
    assign ptr = rr_ptr;
`endif

    uart_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_vld)
    );

    // cnt counts cycles since dataok rose; both phase ends are measured from that point.
    always_ff @(posedge clk50m or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            txdata   <= '0;
            dataok   <= 1'b0;
            ack      <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            rr_ptr   <= IW'(NREQ - 1);
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        txdata    <= bytes[pick];
                        ack[pick] <= 1'b1;
                        grant_id  <= pick;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
                        rr_ptr    <= pick;
`endif
                        dataok    <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= STROBE;
                    end
                end
                STROBE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == DOK_LAST) begin
                        dataok <= 1'b0;
                        state  <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == FRM_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    dataok <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
